// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file widths, control bundle type and x0 constant
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int CTRL_W     = 16;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write bits with set-wins priority and pend lookup
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en_i,
  input  logic [ADDR_WIDTH-1:0]    set_rd_i,
  input  logic                     wb_en_i,
  input  logic [ADDR_WIDTH-1:0]    wb_rd_i,
  input  logic                     flush_en_i,
  input  logic [ADDR_WIDTH-1:0]    flush_rd_i,
  input  logic [ADDR_WIDTH-1:0]    q_rs1_i,
  input  logic [ADDR_WIDTH-1:0]    q_rs2_i,
  input  logic [ADDR_WIDTH-1:0]    q_rd_i,
  output logic                     pend_rs1_o,
  output logic                     pend_rs2_o,
  output logic                     pend_rd_o,
  output logic [2**ADDR_WIDTH-1:0] busy_map_o
);

  localparam int N = 2 ** ADDR_WIDTH;

  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;

  // A writeback landing this cycle is already visible through the bypass, so it does not block.
  function automatic logic pend(input logic [ADDR_WIDTH-1:0] r);
    return busy_q[r] && (r != '0) && !(wb_en_i && (wb_rd_i == r));
  endfunction

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < N; r++) begin
      if (set_en_i && (set_rd_i == ADDR_WIDTH'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wb_en_i && (wb_rd_i == ADDR_WIDTH'(r))) begin
        busy_d[r] = 1'b0;
      end else if (flush_en_i && (flush_rd_i == ADDR_WIDTH'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign pend_rs1_o = pend(q_rs1_i);
  assign pend_rs2_o = pend(q_rs2_i);
  assign pend_rd_o  = pend(q_rd_i);
  assign busy_map_o = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand bypass, RAW/WAW hazard stall and registered bundle into EX
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int CTRL_WIDTH = CTRL_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic [ADDR_WIDTH-1:0]    in_rs1,
  input  logic [ADDR_WIDTH-1:0]    in_rs2,
  input  logic [ADDR_WIDTH-1:0]    in_rd,
  input  logic                     in_regwrite,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [CTRL_WIDTH-1:0]    in_ctrl,
  output logic [ADDR_WIDTH-1:0]    rf_rs1,
  output logic [ADDR_WIDTH-1:0]    rf_rs2,
  input  logic [DATA_WIDTH-1:0]    rf_rd1,
  input  logic [DATA_WIDTH-1:0]    rf_rd2,
  input  logic                     wb_valid,
  input  logic [ADDR_WIDTH-1:0]    wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_pc,
  output logic [DATA_WIDTH-1:0]    out_op1,
  output logic [DATA_WIDTH-1:0]    out_op2,
  output logic [DATA_WIDTH-1:0]    out_imm,
  output logic [ADDR_WIDTH-1:0]    out_rd,
  output logic                     out_regwrite,
  output logic [CTRL_WIDTH-1:0]    out_ctrl,
  output logic [2**ADDR_WIDTH-1:0] busy_map
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(X0);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;

  logic                  pend_rs1, pend_rs2, pend_rd;
  logic                  hazard, accept;
  logic [DATA_WIDTH-1:0] op1, op2;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  always_comb begin
    op1 = rf_rd1;
    op2 = rf_rd2;
    if (in_rs1 == ZERO_REG) op1 = '0;
    else if (wb_valid && (wb_rd == in_rs1)) op1 = wb_data;
    if (in_rs2 == ZERO_REG) op2 = '0;
    else if (wb_valid && (wb_rd == in_rs2)) op2 = wb_data;
  end

  reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (accept && in_regwrite),
    .set_rd_i   (in_rd),
    .wb_en_i    (wb_valid),
    .wb_rd_i    (wb_rd),
    .flush_en_i (flush && valid_q && rw_q),
    .flush_rd_i (rd_q),
    .q_rs1_i    (in_rs1),
    .q_rs2_i    (in_rs2),
    .q_rd_i     (in_rd),
    .pend_rs1_o (pend_rs1),
    .pend_rs2_o (pend_rs2),
    .pend_rd_o  (pend_rd),
    .busy_map_o (busy_map)
  );

  assign hazard   = pend_rs1 || pend_rs2 || (in_regwrite && pend_rd);
  assign in_ready = !hazard && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      op1_d   = op1;
      op2_d   = op2;
      imm_d   = in_imm;
      rd_d    = in_rd;
      rw_d    = in_regwrite;
      ctrl_d  = in_ctrl;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_regwrite = rw_q;
  assign out_ctrl     = ctrl_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch
module tb_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_regwrite;
  logic [DW-1:0] in_pc, in_imm;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic [CW-1:0] in_ctrl;
  logic [AW-1:0] rf_rs1, rf_rs2;
  logic [DW-1:0] rf_rd1, rf_rd2;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          flush;
  logic          out_valid, out_ready, out_regwrite;
  logic [DW-1:0] out_pc, out_op1, out_op2, out_imm;
  logic [AW-1:0] out_rd;
  logic [CW-1:0] out_ctrl;
  logic [NR-1:0] busy_map;

  typedef struct {
    logic [DW-1:0] pc, op1, op2, imm;
    logic [AW-1:0] rd;
    logic          rw;
    logic [CW-1:0] ctrl;
  } bundle_t;

  bundle_t       exp_q[$];
  logic [DW-1:0] regs[NR];
  logic [NR-1:0] m_busy;
  logic          m_ov, m_held_rw;
  logic [AW-1:0] m_held_rd;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  assign rf_rd1 = regs[rf_rs1];
  assign rf_rd2 = regs[rf_rs2];

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_ctrl(out_ctrl), .busy_map(busy_map)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_pend(input logic [AW-1:0] r);
    return m_busy[r] && (r != 0) && !(wb_valid && wb_rd == r);
  endfunction

  function automatic logic [DW-1:0] m_op(input logic [AW-1:0] rs);
    if (rs == 0) return '0;
    if (wb_valid && wb_rd == rs) return wb_data;
    return regs[rs];
  endfunction

  task automatic idle();
    in_valid = 0; in_regwrite = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_pc = 0; in_imm = 0; in_ctrl = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [DW-1:0] pc, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic rw);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_regwrite = rw;
    in_imm = pc ^ 32'hFFFF_0000; in_ctrl = pc[15:0] ^ 16'hA5A5;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    logic          haz, rdy, acc, nov;
    logic [NR-1:0] nb;
    bundle_t       b;
    #1;
    check_eq("rf_rs", {rf_rs1, rf_rs2}, {in_rs1, in_rs2});
    check_eq("busy_map", busy_map, m_busy);
    check_eq("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check_eq("sb_depth", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check_eq("out_pc", out_pc, exp_q[0].pc);
        check_eq("out_op1", out_op1, exp_q[0].op1);
        check_eq("out_op2", out_op2, exp_q[0].op2);
        check_eq("out_imm", out_imm, exp_q[0].imm);
        check_eq("out_rd_rw_ctrl", {out_rd, out_regwrite, out_ctrl},
                 {exp_q[0].rd, exp_q[0].rw, exp_q[0].ctrl});
      end
    end
    haz = m_pend(in_rs1) || m_pend(in_rs2) || (in_regwrite && m_pend(in_rd));
    rdy = !haz && !flush && (!m_ov || out_ready);
    check_eq("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    b.pc = in_pc; b.op1 = m_op(in_rs1); b.op2 = m_op(in_rs2); b.imm = in_imm;
    b.rd = in_rd; b.rw = in_regwrite; b.ctrl = in_ctrl;
    nb = m_busy;
    for (int r = 1; r < NR; r++) begin
      if (acc && in_regwrite && in_rd == AW'(r)) nb[r] = 1'b1;
      else if (wb_valid && wb_rd == AW'(r)) nb[r] = 1'b0;
      else if (flush && m_ov && m_held_rw && m_held_rd == AW'(r)) nb[r] = 1'b0;
    end
    nb[0] = 1'b0;
    nov = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_ov;
    @(posedge clk);
    #1;
    if (m_ov && (out_ready || flush) && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(b);
      m_held_rd = in_rd;
      m_held_rw = in_regwrite;
    end
    m_busy = nb;
    m_ov   = nov;
    if (wb_valid && wb_rd != 0) regs[wb_rd] = wb_data;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h11;
    regs[0] = '0;
    regs[5] = 32'h1234;
    m_busy = '0; m_ov = 0; m_held_rd = '0; m_held_rw = 0;
    rst_n = 0;
    idle();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy_map", busy_map, 0);
    rst_n = 1;
    step();

    // Issue with op1 from the regfile and rs2=x0
    issue(32'h100, 5'd5, 5'd0, 5'd7, 1);
    step();
    idle();
    #1;
    check_eq("t2_op1", out_op1, 32'h1234);
    check_eq("t2_op2", out_op2, 0);
    check_eq("t2_busy7", busy_map[7], 1);
    step();

    // RAW stall until the writeback, then bypassed operand
    issue(32'h104, 5'd7, 5'd0, 5'd8, 1);
    step();
    step();
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hDEAD;
    #1;
    check_eq("t3_ready_on_wb", in_ready, 1);
    step();
    idle();
    #1;
    check_eq("t3_op1_bypass", out_op1, 32'hDEAD);
    step();

    // x0 is never busy and never bypassed
    issue(32'h108, 5'd0, 5'd0, 5'd0, 1);
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    step();
    idle();
    #1;
    check_eq("t4_op1_x0", out_op1, 0);
    check_eq("t4_busy0", busy_map[0], 0);
    step();

    // Backpressure for three cycles, then drain and accept together
    issue(32'h10C, 5'd1, 5'd2, 5'd10, 1);
    step();
    issue(32'h110, 5'd3, 5'd4, 5'd11, 1);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      wb_valid = (k == 1); wb_rd = 5'd8; wb_data = 32'h88;
      step();
    end
    wb_valid = 0;
    out_ready = 1;
    step();
    idle();
    step();
    step();

    // Flush drops the held entry and its pending bit
    issue(32'h200, 5'd0, 5'd0, 5'd9, 1);
    step();
    issue(32'h204, 5'd0, 5'd0, 5'd12, 1);
    out_ready = 0;
    flush = 1;
    step();
    idle();
    #1;
    check_eq("t6_flush_valid", out_valid, 0);
    check_eq("t6_busy9", busy_map[9], 0);
    check_eq("t6_busy12", busy_map[12], 0);
    step();

    // Same-cycle set and writeback of x3: set wins
    issue(32'h300, 5'd0, 5'd0, 5'd3, 1);
    step();
    issue(32'h304, 5'd0, 5'd0, 5'd3, 1);
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h33;
    step();
    idle();
    #1;
    check_eq("t6_busy3_set_wins", busy_map[3], 1);
    step();

    // Asynchronous reset mid-stream
    issue(32'h400, 5'd0, 5'd0, 5'd13, 1);
    #2;
    rst_n = 0;
    #1;
    check_eq("t1_rst_busy", busy_map, 0);
    check_eq("t1_rst_valid", out_valid, 0);
    check_eq("t1_rst_pc", out_pc, 0);
    m_busy = '0; m_ov = 0; exp_q.delete();
    @(negedge clk);
    #1;
    check_eq("t1_rst_hold_busy", busy_map, 0);
    check_eq("t1_rst_hold_valid", out_valid, 0);
    @(negedge clk);
    idle();
    rst_n = 1;
    step();
    issue(32'h500, 5'd5, 5'd3, 5'd13, 1);
    step();
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
